// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: steps through NUM_DIGITS digits of a selectable
// source, with leading-zero suppression, per-digit blink and registered outputs.
module display_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_SRC    = 3,
  parameter int DIGIT_W    = 4,
  parameter int PRESCALE   = 1000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC*NUM_DIGITS*DIGIT_W-1:0]   src_bus,
  input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] mode_sel,
  input  logic [NUM_DIGITS-1:0]                   blink_mask,
  input  logic                                    lz_en,
  output logic [DIGIT_W-1:0]                      digit_out,
  output logic [NUM_DIGITS-1:0]                   digit_en,
  output logic                                    blank_out,
  output logic                                    frame_tick
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PW    = $clog2(PRESCALE);
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [SEL_W-1:0]      src_q, src_d;
  logic [DIGIT_W-1:0]    dout_q, dout_d;
  logic [NUM_DIGITS-1:0] den_q, den_d;
  logic                  blank_q, blank_d;

  logic                  step;
  logic                  wrap;
  logic                  all_zero;
  logic                  blank_now;
  logic [NUM_DIGITS-1:0] supp;
  logic [DIGIT_W-1:0]    digs [NUM_DIGITS];

  always_comb begin
    step = (presc_q == PRESC_LAST);
    wrap = step && (idx_q == IDX_LAST);

    presc_d = step ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (step) idx_d = wrap ? '0 : idx_q + 1'b1;

    // Source and blink state only move at the frame boundary.
    src_d   = src_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (32'(mode_sel) < NUM_SRC) src_d = mode_sel;
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Digits of the active source, scanned top-down to find the all-zero prefix.
  always_comb begin
    all_zero = 1'b1;
    supp     = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      digs[d]  = src_bus[(int'(src_q) * NUM_DIGITS + d) * DIGIT_W +: DIGIT_W];
      all_zero = all_zero & (digs[d] == '0);
      supp[d]  = lz_en && (d >= 1) && all_zero;
    end
  end

  always_comb begin
    blank_now = supp[idx_q] | (blink_mask[idx_q] & phase_q);
    if (blank_now) begin
      den_d   = '0;
      dout_d  = '0;
      blank_d = 1'b1;
    end else begin
      den_d   = NUM_DIGITS'(1) << idx_q;
      dout_d  = digs[idx_q];
      blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      src_q   <= '0;
      dout_q  <= '0;
      den_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      src_q   <= src_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
      blank_q <= blank_d;
    end
  end

  assign digit_out  = dout_q;
  assign digit_en   = den_q;
  assign blank_out  = blank_q;
  // High during the cycle whose closing edge wraps the scan index to 0.
  assign frame_tick = wrap & ~rst;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus random traffic, checked
// cycle by cycle against a time-indexed reference model.
module tb_display_scan_mux;

  localparam int P  = 4;
  localparam int BD = 2;
  localparam int N  = 4;
  localparam int S  = 3;
  localparam int W  = 4;
  localparam int SW = 2;
  localparam int FRAME = P * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [S*N*W-1:0] src_bus = '0;
  logic [SW-1:0]    mode_sel = '0;
  logic [N-1:0]     blink_mask = '0;
  logic             lz_en = 1'b0;
  logic [W-1:0]     digit_out;
  logic [N-1:0]     digit_en;
  logic             blank_out;
  logic             frame_tick;

  int checks   = 0;
  int failures = 0;

  // Reference state: non-reset edges since reset release, and active source.
  int m_t   = 0;
  int m_src = 0;

  logic [N+W:0] exp_q[$];

  display_scan_mux #(
    .NUM_DIGITS(N), .NUM_SRC(S), .DIGIT_W(W), .PRESCALE(P), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .rst(rst), .src_bus(src_bus), .mode_sel(mode_sel),
    .blink_mask(blink_mask), .lz_en(lz_en), .digit_out(digit_out),
    .digit_en(digit_en), .blank_out(blank_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] src_digit(input int s, input int d);
    return src_bus[(s * N + d) * W +: W];
  endfunction

  task automatic set_source(input int s, input int d3, input int d2, input int d1, input int d0);
    src_bus[(s * N + 3) * W +: W] = W'(d3);
    src_bus[(s * N + 2) * W +: W] = W'(d2);
    src_bus[(s * N + 1) * W +: W] = W'(d1);
    src_bus[(s * N + 0) * W +: W] = W'(d0);
  endtask

  // One clock: predict the edge's effect from inputs and model, then compare.
  task automatic run_cycle();
    logic [N+W:0] e;
    logic [N+W:0] g;
    int           idx;
    int           frame;
    int           phase;
    bit           blank;
    bit           supp;
    @(negedge clk);
    check("frame_tick", 32'(frame_tick), 32'(!rst && (m_t % FRAME == FRAME - 1)));
    if (rst) begin
      e     = {1'b1, {N{1'b0}}, {W{1'b0}}};
      m_t   = 0;
      m_src = 0;
    end else begin
      idx   = (m_t / P) % N;
      frame = m_t / FRAME;
      phase = (frame / BD) % 2;
      supp  = 1'b0;
      if (lz_en && idx >= 1) begin
        supp = 1'b1;
        for (int d = idx; d < N; d++)
          if (src_digit(m_src, d) != 0) supp = 1'b0;
      end
      blank = supp || (blink_mask[idx] && phase == 1);
      if (blank) e = {1'b1, {N{1'b0}}, {W{1'b0}}};
      else       e = {1'b0, N'(1 << idx), src_digit(m_src, idx)};
      if (m_t % FRAME == FRAME - 1 && int'(mode_sel) < S) m_src = int'(mode_sel);
      m_t++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    g = {blank_out, digit_en, digit_out};
    check("blank_out", 32'(g[N+W]), 32'(e[N+W]));
    check("digit_en", 32'(g[N+W-1:W]), 32'(e[N+W-1:W]));
    check("digit_out", 32'(g[W-1:0]), 32'(e[W-1:0]));
    check("en_onehot0", 32'($onehot0(digit_en)), 32'(1));
    if (!rst) check("blank_vs_en", 32'(blank_out), 32'(digit_en == '0));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    // Reset and reset values
    rst = 1'b1;
    run_cycles(3);
    rst = 1'b0;

    // Scan test
    set_source(0, 4, 3, 2, 1);
    set_source(1, 9, 8, 7, 6);
    set_source(2, 5, 0, 5, 10);
    run_cycles(3 * FRAME);

    // Mode test: switch mid-frame, then an out-of-range request
    run_cycles(6);
    mode_sel = 2'd2;
    run_cycles(2 * FRAME);
    mode_sel = 2'd3;
    run_cycles(2 * FRAME);
    mode_sel = 2'd0;
    run_cycles(FRAME);

    // Leading-zero suppression
    lz_en = 1'b1;
    set_source(0, 0, 0, 7, 0);
    run_cycles(2 * FRAME);
    set_source(0, 0, 0, 0, 0);
    run_cycles(2 * FRAME);
    lz_en = 1'b0;
    set_source(0, 4, 3, 2, 1);

    // Blink
    blink_mask = 4'b0011;
    run_cycles(8 * FRAME);
    blink_mask = 4'b0000;

    // Reset at scan index 2 mid-dwell
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ((m_t / P) % N == 2 && m_t % P == 1) break;
      run_cycle();
    end
    check("reached_idx2", 32'((m_t / P) % N == 2 && m_t % P == 1), 32'(1));
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    run_cycles(2 * FRAME);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < S * N; k++)
          src_bus[k * W +: W] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 15)) : '0;
      end
      if ($urandom_range(0, 7) == 0) mode_sel   = SW'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) blink_mask = N'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) lz_en      = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      run_cycle();
    end
    rst = 1'b0;
    run_cycles(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
